universal_mod_counter: RTL
==========================

# universal_mod_counter

Parametrised successor to the 8-bit universal binary counter. Counts up or down by a programmable step inside a programmable range 0..lim, and either wraps or saturates at the range limits. Flags wrap-around and overflow for the display and timer logic that consumes it. Synchronous clear and parallel load are kept, so the block drops in wherever the fixed-width counter was used.

## Interface
- W, 8: counter width in bits.
- STEP_W, 4: width of the step input.
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- syn_clr  in  1  synchronous clear; highest priority.
- load  in  1  synchronous parallel load of d.
- d  in  W  load value.
- en  in  1  count enable.
- up  in  1  1 = count up, 0 = count down.
- sat  in  1  1 = saturate at limits, 0 = wrap modulo lim+1.
- lim  in  W  inclusive upper bound of the count range.
- step  in  STEP_W  count increment per enabled cycle.
- ovf_clr  in  1  clears the sticky ovf flag.
- q  out  W  counter value, registered.
- max_tick  out  1  combinational: q == lim.
- min_tick  out  1  combinational: q == 0.
- wrap  out  1  registered one-cycle pulse; high while q holds a post-wrap value.
- ovf  out  1  sticky flag, set on any wrap, clip, or clamp.

## Operation
- Reset (reset = 0, asynchronous): q = 0, wrap = 0, ovf = 0.
- Priority per edge is syn_clr > load > en; with none of them active, q holds and wrap = 0.
- syn_clr: q = 0, wrap = 0, ovf = 0.
- load:
  - d <= lim: q = d.
  - d > lim: q = lim and ovf is set.
  - wrap = 0.
- Effective step s = min(step, lim+1), computed in W+1 bits. s = 0 means q holds and no event occurs.
- Out-of-range guard: if en and q > lim (lim was lowered mid-count):
  - q = 0 when up = 1, q = lim when up = 0.
  - ovf is set; wrap = 0.
- Up count, sum = q + s in W+1 bits:
  - sum <= lim: q = sum.
  - sum > lim, sat = 0: q = sum - (lim+1); wrap = 1; ovf set.
  - sum > lim, sat = 1: q = lim; ovf set; wrap = 0.
- Down count:
  - s <= q: q = q - s.
  - s > q, sat = 0: q = q + (lim+1) - s; wrap = 1; ovf set.
  - s > q, sat = 1: q = 0; ovf set; wrap = 0.
- All intermediate arithmetic is W+1 bits, so lim = 2^W-1 gives a full binary modulo-2^W counter.
- ovf_clr clears ovf unless a set event occurs on the same edge; set wins.
- lim = 0: q is held at 0. Any nonzero step in wrap mode pulses wrap and sets ovf each enabled cycle.

## Timing
- q, wrap and ovf are registered and change only on the rising clk edge, or asynchronously on reset assertion.
- Latency is one cycle from a control input to the q update.
- wrap is high for exactly the cycle after the wrapping edge, aligned with the new q. Consecutive wrapping edges keep it high.
- max_tick and min_tick are combinational from q and lim. They follow lim changes within the same cycle.
- Reset deassertion is synchronised externally. The first active edge after release evaluates normally.
- Reset asserted mid-count returns all outputs to reset values immediately. Nothing is retained.

## Test plan
- Reset/wrap up: release reset; W = 8, lim = 9, step = 1, up = 1, sat = 0, en = 1 for 12 cycles -> q = 0,1,…,9,0,1. max_tick is high when q = 9. wrap pulses once with q = 0. ovf = 1 afterwards.
- Saturate down with large step: load d = 5, then up = 0, sat = 1, step = 3 -> q = 2, then 0, then holds 0. min_tick = 1. ovf = 1. wrap is never high.
- Modulo step wrap: lim = 9, q = 8, step = 5, up = 1, sat = 0 -> q = 3, wrap = 1. Down from q = 2 with step = 4 -> q = 8, wrap = 1.
- Priority and clamp:
  - syn_clr, load and en high together with d = 7 -> q = 0, ovf = 0.
  - Then load d = 200 with lim = 100 -> q = 100, ovf = 1.
  - Then ovf_clr alone -> ovf = 0.
- lim lowered mid-count: q = 50, lim changed to 20, en, up = 1 -> q = 0, ovf = 1, wrap = 0. max_tick goes low combinationally in the same cycle as the lim change.
- Asynchronous reset mid-count: assert reset between clock edges with q = 6, ovf = 1 -> q = 0, ovf = 0 and wrap = 0 before the next edge. The count resumes from 0 after release.

Source files
------------

// File: rtl/universal_mod_counter.sv
// Up/down counter with programmable step and inclusive range 0..lim.
// Wraps modulo lim+1 or saturates at the limits; sticky ovf records any wrap, clip or clamp.
module universal_mod_counter #(
  parameter int W      = 8,
  parameter int STEP_W = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              syn_clr,
  input  logic              load,
  input  logic [W-1:0]      d,
  input  logic              en,
  input  logic              up,
  input  logic              sat,
  input  logic [W-1:0]      lim,
  input  logic [STEP_W-1:0] step,
  input  logic              ovf_clr,
  output logic [W-1:0]      q,
  output logic              max_tick,
  output logic              min_tick,
  output logic              wrap,
  output logic              ovf
);

  // Step clamp is compared wide enough for either operand, then narrowed to W+1 bits.
  localparam int CW = (STEP_W > W + 1) ? STEP_W : W + 1;

  logic [CW-1:0] lim_p1_c;
  logic [CW-1:0] step_c;
  logic [CW-1:0] s_c;
  logic [W:0]    s;
  logic [W:0]    lim_x;
  logic [W:0]    lim_p1;
  logic [W:0]    q_x;
  logic [W:0]    sum;
  logic [W:0]    up_wrap;
  logic [W:0]    dn_wrap;
  logic [W-1:0]  q_nxt;
  logic          wrap_nxt;
  logic          ovf_set;
  logic          unused_bits;

  assign lim_p1_c = CW'(lim) + CW'(1);
  assign step_c   = CW'(step);
  assign s_c      = (step_c < lim_p1_c) ? step_c : lim_p1_c;
  assign s        = s_c[W:0];

  assign lim_x   = {1'b0, lim};
  assign lim_p1  = lim_x + {{W{1'b0}}, 1'b1};
  assign q_x     = {1'b0, q};
  assign sum     = q_x + s;
  assign up_wrap = sum - lim_p1;
  assign dn_wrap = q_x + lim_p1 - s;

  assign unused_bits = ^{up_wrap[W], dn_wrap[W], s_c};

  always_comb begin
    q_nxt    = q;
    wrap_nxt = 1'b0;
    ovf_set  = 1'b0;
    if (syn_clr) begin
      q_nxt = '0;
    end else if (load) begin
      if (d > lim) begin
        q_nxt   = lim;
        ovf_set = 1'b1;
      end else begin
        q_nxt = d;
      end
    end else if (en) begin
      // q can sit above lim only if lim was lowered under it; pull it back into range.
      if (q > lim) begin
        q_nxt   = up ? '0 : lim;
        ovf_set = 1'b1;
      end else if (s != '0) begin
        if (up) begin
          if (sum <= lim_x) begin
            q_nxt = sum[W-1:0];
          end else if (sat) begin
            q_nxt   = lim;
            ovf_set = 1'b1;
          end else begin
            q_nxt    = up_wrap[W-1:0];
            wrap_nxt = 1'b1;
            ovf_set  = 1'b1;
          end
        end else begin
          if (s <= q_x) begin
            q_nxt = q - s[W-1:0];
          end else if (sat) begin
            q_nxt   = '0;
            ovf_set = 1'b1;
          end else begin
            q_nxt    = dn_wrap[W-1:0];
            wrap_nxt = 1'b1;
            ovf_set  = 1'b1;
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q    <= '0;
      wrap <= 1'b0;
      ovf  <= 1'b0;
    end else begin
      q    <= q_nxt;
      wrap <= wrap_nxt;
      if (syn_clr)      ovf <= 1'b0;
      else if (ovf_set) ovf <= 1'b1;
      else if (ovf_clr) ovf <= 1'b0;
    end
  end

  assign max_tick = (q == lim);
  assign min_tick = (q == '0);

endmodule
